// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one combinational alu between two requesters.
// Operations run IDLE -> EXEC -> RESP; the result is held until the consumer takes it.

module alu4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   sel,
    output logic [W-1:0] out,
    output logic [4:0]   flags
);
    // sel: 00 add, 01 sub (carry = borrow), 10 and, 11 xor.
    // flags = {zero, carry, sign, parity (xor of out bits), signed overflow}.
    logic [W:0] wide;
    logic       carry;
    logic       ovf;

    always_comb begin
        wide  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        out   = '0;
        case (sel)
            2'b00: begin
                wide  = {1'b0, a} + {1'b0, b};
                out   = wide[W-1:0];
                carry = wide[W];
                ovf   = (a[W-1] == b[W-1]) && (out[W-1] != a[W-1]);
            end
            2'b01: begin
                wide  = {1'b0, a} - {1'b0, b};
                out   = wide[W-1:0];
                carry = wide[W];
                ovf   = (a[W-1] != b[W-1]) && (out[W-1] != a[W-1]);
            end
            2'b10:   out = a & b;
            default: out = a ^ b;
        endcase
        flags = {~|out, carry, out[W-1], ^out, ovf};
    end
endmodule

module alu_rr_sequencer #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [2*W-1:0]   req_a,
    input  logic [2*W-1:0]   req_b,
    input  logic [3:0]       req_sel,
    output logic [1:0]       req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_out,
    output logic [4:0]       rsp_flags,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1,
    output logic [1:0]       dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. req_ready is combinational and one-hot (or zero); rsp_valid,
    // once high, stays high with rsp_* stable until rsp_ready is seen.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [W-1:0]       op_a_q, op_a_d;
    logic [W-1:0]       op_b_q, op_b_d;
    logic [1:0]         op_sel_q, op_sel_d;
    logic               op_id_q, op_id_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [W-1:0]       rsp_out_q, rsp_out_d;
    logic [4:0]         rsp_flags_q, rsp_flags_d;
    logic [CNT_W-1:0]   done_cnt0_q, done_cnt0_d;
    logic [CNT_W-1:0]   done_cnt1_q, done_cnt1_d;

    logic               grant_valid;
    logic               grant_id;
    logic [W-1:0]       alu_out;
    logic [4:0]         alu_flags;

    // The alu only ever sees the captured operands, never the live request inputs.
    alu4 #(.W(W)) u_alu (
        .a     (op_a_q),
        .b     (op_b_q),
        .sel   (op_sel_q),
        .out   (alu_out),
        .flags (alu_flags)
    );

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_q == IDLE) begin
            case (req_valid)
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_id    = 1'b1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_id    = ~last_grant_q;
                end
                default: grant_valid = 1'b0;
            endcase
        end
        req_ready = 2'b00;
        if (grant_valid) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_flags_d  = rsp_flags_q;
        done_cnt0_d  = done_cnt0_q;
        done_cnt1_d  = done_cnt1_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    op_a_d       = grant_id ? req_a[2*W-1:W] : req_a[W-1:0];
                    op_b_d       = grant_id ? req_b[2*W-1:W] : req_b[W-1:0];
                    op_sel_d     = grant_id ? req_sel[3:2] : req_sel[1:0];
                    op_id_d      = grant_id;
                    last_grant_d = grant_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_out_d   = alu_out;
                rsp_flags_d = alu_flags;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_id_q) begin
                        done_cnt1_d = done_cnt1_q + CNT_W'(1);
                    end else begin
                        done_cnt0_d = done_cnt0_q + CNT_W'(1);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= '0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= '0;
            rsp_flags_q  <= '0;
            done_cnt0_q  <= '0;
            done_cnt1_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_flags_q  <= rsp_flags_d;
            done_cnt0_q  <= done_cnt0_d;
            done_cnt1_q  <= done_cnt1_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;
    assign done_cnt0 = done_cnt0_q;
    assign done_cnt1 = done_cnt1_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Self-checking bench for alu_rr_sequencer: per-scenario tasks plus a response scoreboard.

module tb_alu_rr_sequencer;
    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] req_sel;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_out;
    logic [4:0] rsp_flags;
    logic [7:0] done_cnt0;
    logic [7:0] done_cnt1;
    logic [1:0] dbg_state;

    int errors = 0;
    int checks = 0;

    // entry = {id, zero, carry, sign, parity, overflow, out}
    logic [9:0] exp_q[$];

    alu_rr_sequencer #(.W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_flags (rsp_flags),
        .done_cnt0 (done_cnt0),
        .done_cnt1 (done_cnt1),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [8:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] sel);
        int         ua;
        int         ub;
        int         sa;
        int         sb;
        int         s;
        logic [3:0] r;
        logic       c;
        logic       v;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 7) ? ua - 16 : ua;
        sb = (ub > 7) ? ub - 16 : ub;
        r  = 4'h0;
        c  = 1'b0;
        v  = 1'b0;
        case (sel)
            2'b00: begin
                r = 4'((ua + ub) % 16);
                c = (ua + ub) > 15;
                s = sa + sb;
                v = (s > 7) || (s < -8);
            end
            2'b01: begin
                r = 4'((ua - ub + 16) % 16);
                c = ua < ub;
                s = sa - sb;
                v = (s > 7) || (s < -8);
            end
            2'b10:   r = a & b;
            default: r = a ^ b;
        endcase
        return {(r == 4'h0), c, r[3], (r[0] ^ r[1] ^ r[2] ^ r[3]), v, r};
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] sel);
        bit got;
        got = 0;
        if (id) begin
            req_a[7:4] = a; req_b[7:4] = b; req_sel[3:2] = sel;
        end else begin
            req_a[3:0] = a; req_b[3:0] = b; req_sel[1:0] = sel;
        end
        req_valid[id] = 1'b1;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id] === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout id=%0d req_ready=%b expected grant within 12 cycles", id, req_ready);
        end else begin
            exp_q.push_back({id, alu_model(a, b, sel)});
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        // Operands change freely after acceptance; the result must not follow them.
        if (id) begin
            req_a[7:4] = 4'($urandom); req_b[7:4] = 4'($urandom); req_sel[3:2] = 2'($urandom);
        end else begin
            req_a[3:0] = 4'($urandom); req_b[3:0] = 4'($urandom); req_sel[1:0] = 2'($urandom);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [9:0] exp;
        if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got={id=%0d out=%h flags=%b} expected no response",
                         rsp_id, rsp_out, rsp_flags);
            end else begin
                exp = exp_q.pop_front();
                if ({rsp_id, rsp_flags, rsp_out} !== exp) begin
                    errors++;
                    $display("FAIL rsp_data got={id=%0d flags=%b out=%h} expected={id=%0d flags=%b out=%h}",
                             rsp_id, rsp_flags, rsp_out, exp[9], exp[8:4], exp[3:0]);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 2'b00 || rsp_valid !== 1'b0 || done_cnt0 !== 8'd0 || done_cnt1 !== 8'd0) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d got ready=%b rsp_valid=%b cnt0=%0d cnt1=%0d expected 00/0/0/0",
                         i, req_ready, rsp_valid, done_cnt0, done_cnt1);
            end
        end
        checks++;
        if (rsp_id !== 1'b0 || rsp_out !== 4'h0 || rsp_flags !== 5'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_values got id=%0d out=%h flags=%b state=%0d expected 0/0/0/0",
                     rsp_id, rsp_out, rsp_flags, dbg_state);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_add();
        issue(1'b0, 4'h3, 4'h5, 2'b00);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_latency_exec got rsp_valid=%b expected 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 4'h8 || rsp_flags !== 5'b00111) begin
            errors++;
            $display("FAIL add_result got valid=%b id=%0d out=%h flags=%b expected 1/0/8/00111",
                     rsp_valid, rsp_id, rsp_out, rsp_flags);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || done_cnt0 !== 8'd1 || done_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL add_done got valid=%b cnt0=%0d cnt1=%0d expected 0/1/0",
                     rsp_valid, done_cnt0, done_cnt1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic exp_id;
        logic got_id;
        bit   acc;
        int   grants;
        do_reset();
        @(posedge clk); #1;
        exp_id = 1'b0;
        grants = 0;
        req_a = 8'($urandom); req_b = 8'($urandom); req_sel = 4'($urandom);
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk);
            acc = 0;
            got_id = 1'b0;
            if (req_ready !== 2'b00) begin
                acc = 1;
                got_id = req_ready[1];
                checks++;
                if ((req_ready !== 2'b01 && req_ready !== 2'b10) || got_id !== exp_id) begin
                    errors++;
                    $display("FAIL rr_grant n=%0d got ready=%b expected id=%0d", grants, req_ready, exp_id);
                end
                exp_q.push_back({got_id, alu_model(got_id ? req_a[7:4] : req_a[3:0],
                                                   got_id ? req_b[7:4] : req_b[3:0],
                                                   got_id ? req_sel[3:2] : req_sel[1:0])});
                grants++;
                exp_id = ~exp_id;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (got_id) begin
                    req_a[7:4] = 4'($urandom); req_b[7:4] = 4'($urandom); req_sel[3:2] = 2'($urandom);
                end else begin
                    req_a[3:0] = 4'($urandom); req_b[3:0] = 4'($urandom); req_sel[1:0] = 2'($urandom);
                end
            end
        end
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (grants != 6 || done_cnt0 !== 8'd3 || done_cnt1 !== 8'd3 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_counts got grants=%0d cnt0=%0d cnt1=%0d valid=%b expected 6/3/3/0",
                     grants, done_cnt0, done_cnt1, rsp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] cnt1_before;
        logic [9:0] head;
        cnt1_before = done_cnt1;
        rsp_ready = 1'b0;
        issue(1'b1, 4'h9, 4'h4, 2'b01);
        req_a[3:0] = 4'h6; req_b[3:0] = 4'h6; req_sel[1:0] = 2'b11;
        req_valid[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_exec got ready=%b valid=%b expected 00/0", req_ready, rsp_valid);
        end
        head = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || {rsp_id, rsp_flags, rsp_out} !== head || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got valid=%b rsp=%h ready=%b expected 1/%h/00",
                         i, rsp_valid, {rsp_id, rsp_flags, rsp_out}, req_ready, head);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_hold got valid=%b expected 1", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 2'b01 || done_cnt1 !== cnt1_before + 8'd1) begin
            errors++;
            $display("FAIL bp_release got valid=%b ready=%b cnt1=%0d expected 0/01/%0d",
                     rsp_valid, req_ready, done_cnt1, cnt1_before + 8'd1);
        end
        if (req_ready === 2'b01) exp_q.push_back({1'b0, alu_model(4'h6, 4'h6, 2'b11)});
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        logic id;
        issue(1'b0, 4'hF, 4'h1, 2'b00);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_out !== 4'h0 || rsp_flags !== 5'b11000) begin
            errors++;
            $display("FAIL wrap_add got valid=%b out=%h flags=%b expected 1/0/11000",
                     rsp_valid, rsp_out, rsp_flags);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) begin
            id = 1'($urandom_range(0, 1));
            issue(id, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        issue(1'b0, 4'h7, 4'h7, 2'b00);
        void'(exp_q.pop_back());
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || dbg_state !== 2'd0 || done_cnt0 !== 8'd0 || done_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL rst_exec got valid=%b state=%0d cnt0=%0d cnt1=%0d expected 0/0/0/0",
                     rsp_valid, dbg_state, done_cnt0, done_cnt1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 4'h2, 4'hC, 2'b01);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_resp_pre got valid=%b expected 1", rsp_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_out !== 4'h0 || done_cnt0 !== 8'd0 || done_cnt1 !== 8'd0) begin
            errors++;
            $display("FAIL rst_resp got valid=%b out=%h cnt0=%0d cnt1=%0d expected 0/0/0/0",
                     rsp_valid, rsp_out, done_cnt0, done_cnt1);
        end
        void'(exp_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_a = 8'h51; req_b = 8'h32; req_sel = 4'b1000;
        req_valid = 2'b11;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_tie got ready=%b expected 01", req_ready);
        end
        if (req_ready === 2'b01) exp_q.push_back({1'b0, alu_model(4'h1, 4'h2, 2'b00)});
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (done_cnt0 !== 8'd1 || done_cnt1 !== 8'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rst_final got cnt0=%0d cnt1=%0d pending=%0d expected 1/0/0",
                     done_cnt0, done_cnt1, exp_q.size());
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = 8'h00;
        req_b     = 8'h00;
        req_sel   = 4'h0;
        rsp_ready = 1'b1;
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_sweep();
        test_reset_mid_op();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
